// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared interrupt constants and MSB priority encoder
package irq_pkg;

    localparam int N_IRQ           = 3;
    localparam int ID_W            = 2;
    localparam int DEBOUNCE_CYCLES = 20;
    localparam int CNT_W           = 5;

    // Index of the most significant set bit; 0 when the vector is empty.
    function automatic logic [7:0] prio_enc(input logic [31:0] v);
        logic [7:0] idx;
        idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) begin
                idx = 8'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - one button channel: 2-flop synchroniser, debounce counter, rise pulse
module btn_debounce
    import irq_pkg::*;
#(
    parameter int DEB_CYCLES = irq_pkg::DEBOUNCE_CYCLES,
    parameter int CW         = irq_pkg::CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    logic          sync1_q, sync2_q;
    logic          db_level_q, db_level_d;
    logic          db_prev_q;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        db_level_d = db_level_q;
        cnt_d      = '0;
        if (sync2_q != db_level_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                db_level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            db_level_q <= 1'b0;
            db_prev_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sync1_q    <= btn;
            sync2_q    <= sync1_q;
            db_level_q <= db_level_d;
            db_prev_q  <= db_level_q;
            cnt_q      <= cnt_d;
        end
    end

    assign rise = db_level_q & ~db_prev_q;

endmodule

// File: rtl/irq_request_unit.sv
// rtl/irq_request_unit.sv - debounced button interrupts: pending latch, masking, priority request
module irq_request_unit
    import irq_pkg::*;
#(
    parameter int N_IRQ           = irq_pkg::N_IRQ,
    parameter int ID_W            = irq_pkg::ID_W,
    parameter int DEBOUNCE_CYCLES = irq_pkg::DEBOUNCE_CYCLES,
    parameter int CNT_W           = irq_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] btn,
    input  logic [N_IRQ-1:0] irq_mask,
    input  logic             irq_ack,
    input  logic [ID_W-1:0]  irq_ack_id,
    output logic             irq_req,
    output logic [ID_W-1:0]  irq_id,
    output logic [N_IRQ-1:0] irq_pending
);

    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] clr;
    logic [N_IRQ-1:0] eligible;
    logic [N_IRQ-1:0] pending_q, pending_d;
    logic             irq_req_q, irq_req_d;
    logic [ID_W-1:0]  irq_id_q, irq_id_d;

    for (genvar g = 0; g < N_IRQ; g++) begin : g_ch
        btn_debounce #(
            .DEB_CYCLES (DEBOUNCE_CYCLES),
            .CW         (CNT_W)
        ) u_db (
            .clk  (clk),
            .rst  (rst),
            .btn  (btn[g]),
            .rise (rise[g])
        );
    end

    // A new rise beats a simultaneous ack so the fresh edge is never lost.
    always_comb begin
        clr = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            clr[i] = irq_ack && (irq_ack_id == ID_W'(i));
        end
        pending_d = (pending_q & ~clr) | rise;
        eligible  = pending_q & ~irq_mask;
        irq_req_d = |eligible;
        irq_id_d  = ID_W'(prio_enc(32'(eligible)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            irq_req_q <= 1'b0;
            irq_id_q  <= '0;
        end else begin
            pending_q <= pending_d;
            irq_req_q <= irq_req_d;
            irq_id_q  <= irq_id_d;
        end
    end

    assign irq_pending = pending_q;
    assign irq_req     = irq_req_q;
    assign irq_id      = irq_id_q;

endmodule
